// File: rtl/led_timer_multi_if.sv
// AXI4-Lite bundle for led_timer_multi.
// master: aw/w/ar requests + bready/rready; slave: ready/resp/data.
interface led_timer_multi_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/led_timer_multi.sv
// Multi-channel LED timer, AXI4-Lite slave (s00_axi), shared prescaler.
// Ports: s00_axi_aclk/aresetn, s00_axi bus, led[NUM_CH], irq.
module led_timer_multi #(
  parameter int NUM_CH               = 4,
  parameter int CNT_WIDTH            = 32,
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 8
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  led_timer_multi_if.slave  s00_axi,
  output logic [NUM_CH-1:0] led,
  output logic              irq
);
  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int HW = AW - 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  logic clk;
  logic rst_n;
  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  logic              en;
  logic [15:0]       prescale;
  logic [15:0]       presc;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] blink;
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] w1c;
  logic [NUM_CH-1:0] wr_ch;
  cnt_t              period  [NUM_CH];
  cnt_t              compare [NUM_CH];
  cnt_t              count   [NUM_CH];
  logic [1:0]        mode    [NUM_CH];

  logic          aw_rdy;
  logic          ar_rdy;
  logic          b_vld;
  logic          r_vld;
  logic [DW-1:0] r_data;
  logic [DW-1:0] rd_mux;
  logic          wr;
  logic          rd;
  logic          wr_glb;
  logic          tick;
  logic          clr;
  logic          unused;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] d,
    input logic [SW-1:0] s
  );
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < SW; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  assign s00_axi.awready = aw_rdy;
  assign s00_axi.wready  = aw_rdy;
  assign s00_axi.bvalid  = b_vld;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = ar_rdy;
  assign s00_axi.rvalid  = r_vld;
  assign s00_axi.rdata   = r_data;
  assign s00_axi.rresp   = 2'b00;

  assign unused = ^{s00_axi.awprot, s00_axi.arprot,
                    s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // aw_rdy is only raised while both valids are up, so it marks the handshake
  assign wr = aw_rdy && s00_axi.awvalid && s00_axi.wvalid;
  assign rd = ar_rdy && s00_axi.arvalid;

  assign wr_glb = wr && (s00_axi.awaddr[AW-1:4] == '0);
  assign clr = wr_glb && (s00_axi.awaddr[3:2] == 2'd0)
            && s00_axi.wstrb[0] && s00_axi.wdata[1];
  assign w1c = (wr_glb && (s00_axi.awaddr[3:2] == 2'd1))
             ? NUM_CH'(merge('0, s00_axi.wdata, s00_axi.wstrb))
             : '0;

  // channel n lives in the 16-byte block n+1
  always_comb begin
    wr_ch = '0;
    for (int n = 0; n < NUM_CH; n++)
      wr_ch[n] = wr && (s00_axi.awaddr[AW-1:4] == HW'(n + 1));
  end

  assign tick = en && !clr && (presc >= prescale);

  always_comb begin
    wrap = '0;
    for (int n = 0; n < NUM_CH; n++)
      wrap[n] = tick && (count[n] >= period[n]);
  end

  always_comb begin
    rd_mux = '0;
    if (s00_axi.araddr[AW-1:4] == '0) begin
      case (s00_axi.araddr[3:2])
        2'd0:    rd_mux = DW'(en);
        2'd1:    rd_mux = DW'(status);
        2'd2:    rd_mux = DW'(prescale);
        default: rd_mux = DW'(irq_en);
      endcase
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (s00_axi.araddr[AW-1:4] == HW'(n + 1)) begin
        case (s00_axi.araddr[3:2])
          2'd0:    rd_mux = DW'(period[n]);
          2'd1:    rd_mux = DW'(compare[n]);
          2'd2:    rd_mux = DW'(mode[n]);
          default: rd_mux = DW'(count[n]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      aw_rdy <= !aw_rdy && s00_axi.awvalid
             && s00_axi.wvalid && !b_vld;
      if (wr)
        b_vld <= 1'b1;
      else if (s00_axi.bready)
        b_vld <= 1'b0;
      ar_rdy <= !ar_rdy && s00_axi.arvalid && !r_vld;
      if (rd) begin
        r_vld  <= 1'b1;
        r_data <= rd_mux;
      end else if (s00_axi.rready) begin
        r_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en       <= 1'b0;
      prescale <= '0;
      irq_en   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        period[n]  <= '0;
        compare[n] <= '0;
        mode[n]    <= '0;
      end
    end else begin
      if (wr_glb) begin
        case (s00_axi.awaddr[3:2])
          2'd0: if (s00_axi.wstrb[0]) en <= s00_axi.wdata[0];
          2'd2: prescale <= 16'(merge(DW'(prescale),
                                      s00_axi.wdata, s00_axi.wstrb));
          2'd3: irq_en <= NUM_CH'(merge(DW'(irq_en),
                                        s00_axi.wdata, s00_axi.wstrb));
          default: ;
        endcase
      end
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_ch[n]) begin
          case (s00_axi.awaddr[3:2])
            2'd0: period[n] <= cnt_t'(merge(DW'(period[n]),
                                  s00_axi.wdata, s00_axi.wstrb));
            2'd1: compare[n] <= cnt_t'(merge(DW'(compare[n]),
                                   s00_axi.wdata, s00_axi.wstrb));
            2'd2: mode[n] <= 2'(merge(DW'(mode[n]),
                                s00_axi.wdata, s00_axi.wstrb));
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc  <= '0;
      blink  <= '0;
      status <= '0;
      led    <= '0;
      irq    <= 1'b0;
      for (int n = 0; n < NUM_CH; n++)
        count[n] <= '0;
    end else begin
      if (!en || clr || tick)
        presc <= '0;
      else
        presc <= presc + 16'd1;
      for (int n = 0; n < NUM_CH; n++) begin
        if (clr) begin
          count[n] <= '0;
          blink[n] <= 1'b0;
        end else if (tick) begin
          // >= so a PERIOD shrunk below COUNT wraps instead of overflowing
          count[n] <= wrap[n] ? '0 : count[n] + cnt_t'(1);
          if (wrap[n]) blink[n] <= ~blink[n];
        end
        case (mode[n])
          2'd0:    led[n] <= 1'b0;
          2'd1:    led[n] <= 1'b1;
          2'd2:    led[n] <= blink[n];
          default: led[n] <= (count[n] < compare[n]);
        endcase
      end
      // a wrap in the same cycle as its W1C keeps the bit set
      status <= (status & ~w1c) | wrap;
      irq    <= |(status & irq_en);
    end
  end
endmodule

// File: tb/tb_led_timer_multi.sv
// Directed bench for led_timer_multi.
// AXI-Lite master tasks, hand-computed expectations.
module tb_led_timer_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led;
  logic       irq;
  int         total = 0;
  int         bad = 0;
  int         irq_drops = 0;
  bit         mon_irq = 1'b0;

  led_timer_multi_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  led_timer_multi #(
    .NUM_CH(4),
    .CNT_WIDTH(32),
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(8)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi(bus),
    .led(led),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mon_irq && !irq) irq_drops++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s = 4'hF);
    @(negedge clk);
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    for (int i = 0; i < 20 && !bus.awready; i++) @(negedge clk);
    if (!bus.awready) chk("aw_timeout", 32'(bus.awready), 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (bus.bready) begin
      for (int i = 0; i < 20 && bus.bvalid; i++) @(negedge clk);
      if (bus.bvalid) chk("b_timeout", 32'(bus.bvalid), 0);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !bus.arready; i++) @(negedge clk);
    if (!bus.arready) chk("ar_timeout", 32'(bus.arready), 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (!bus.rvalid) chk("r_timeout", 32'(bus.rvalid), 1);
    d = bus.rdata;
    @(negedge clk);
  endtask

  task automatic rdchk(input logic [7:0] a, input logic [31:0] exp,
                       input string tag);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] v2;
    logic [3:0]  ls;
    logic        prev;
    logic        lv;
    logic        found;
    int          ones;
    int          stab;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(led), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    rst_n = 1'b1;
    for (int a = 0; a < 80; a += 4)
      rdchk(8'(a), 0, "rst_reg");

    wr(8'h10, 32'hA5A5A5A5, 4'b0011);
    rdchk(8'h10, 32'h0000A5A5, "strb_period0");
    rdchk(8'h7C, 0, "unmapped_7c");
    wr(8'h54, 32'h12345678);
    rdchk(8'h54, 0, "ch4_ignored");
    rdchk(8'h14, 0, "ch0_cmp_untouched");

    wr(8'h20, 9);
    wr(8'h24, 3);
    wr(8'h28, 3);
    wr(8'h00, 1);
    repeat (5) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      ones += int'(led[1]);
    end
    chk("pwm_c3_duty", 32'(ones), 9);
    wr(8'h24, 12);
    repeat (3) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ones += int'(led[1]);
    end
    chk("pwm_c12_on", 32'(ones), 20);
    wr(8'h24, 0);
    repeat (3) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ones += int'(led[1]);
    end
    chk("pwm_c0_off", 32'(ones), 0);
    wr(8'h24, 12);

    wr(8'h08, 1);
    wr(8'h30, 4);
    wr(8'h38, 2);
    repeat (25) @(negedge clk);
    prev = led[2];
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (led[2] != prev) found = 1'b1;
    end
    chk("blink_seen", 32'(found), 1);
    lv = led[2];
    stab = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (led[2] != lv) stab++;
    end
    @(negedge clk);
    chk("blink_stable", 32'(stab), 0);
    chk("blink_toggle10", 32'(led[2]), 32'(!lv));

    wr(8'h00, 0);
    rd(8'h3C, v);
    chk("cnt2_range", 32'(v <= 4), 1);
    ls = led;
    repeat (20) @(negedge clk);
    chk("freeze_led", 32'(led), 32'(ls));
    rd(8'h3C, v2);
    chk("freeze_cnt2", v2, v);
    wr(8'h00, 2);
    rdchk(8'h3C, 0, "clr_cnt2");
    rdchk(8'h2C, 0, "clr_cnt1");
    rdchk(8'h00, 0, "ctrl_clr_reads0");
    rdchk(8'h20, 9, "clr_keeps_period");

    wr(8'h04, 32'hF);
    rdchk(8'h04, 0, "status_w1c_all");
    wr(8'h08, 0);
    wr(8'h0C, 1);
    wr(8'h10, 2);
    chk("irq_idle", 32'(irq), 0);
    wr(8'h00, 1);
    for (int i = 0; i < 20 && !irq; i++) @(negedge clk);
    chk("irq_rise", 32'(irq), 1);
    rd(8'h04, v);
    chk("status0_set", 32'(v[0]), 1);
    wr(8'h10, 0);
    mon_irq = 1'b1;
    wr(8'h04, 1);
    repeat (3) @(negedge clk);
    mon_irq = 1'b0;
    chk("w1c_set_wins", 32'(irq_drops), 0);
    wr(8'h00, 0);
    wr(8'h04, 1);
    chk("irq_drop", 32'(irq), 0);
    rd(8'h04, v);
    chk("status0_cleared", 32'(v[0]), 0);

    wr(8'h40, 100);
    wr(8'h04, 32'hF);
    rdchk(8'h04, 0, "status_w1c_all2");
    wr(8'h00, 1);
    v = 0;
    for (int i = 0; i < 40 && v < 50; i++) rd(8'h4C, v);
    chk("cnt3_reach50", 32'(v >= 50), 1);
    rd(8'h04, v2);
    chk("st3_before", 32'(v2[3]), 0);
    wr(8'h40, 10);
    rd(8'h4C, v);
    chk("cnt3_wrapped", 32'(v <= 10), 1);
    rd(8'h04, v2);
    chk("st3_after", 32'(v2[3]), 1);

    chk("led1_pre_rst", 32'(led[1]), 1);
    bus.bready = 1'b0;
    wr(8'h0C, 32'hF);
    repeat (2) @(negedge clk);
    chk("bvalid_hold", 32'(bus.bvalid), 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_bvalid", 32'(bus.bvalid), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2_bvalid_after", 32'(bus.bvalid), 0);
    chk("rst2_rvalid", 32'(bus.rvalid), 0);
    chk("rst2_led", 32'(led), 0);
    chk("rst2_irq", 32'(irq), 0);
    bus.bready = 1'b1;
    rdchk(8'h00, 0, "rst2_ctrl");
    rdchk(8'h04, 0, "rst2_status");
    rdchk(8'h0C, 0, "rst2_irq_en");
    rdchk(8'h20, 0, "rst2_period1");
    rdchk(8'h40, 0, "rst2_period3");
    rdchk(8'h28, 0, "rst2_mode1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
